priority_encoder_8x3: RTL and testbench
=======================================

# priority_encoder_8x3

Sequential 8-to-3 priority encoder. Collects request pulses on eight lines into a pending register and issues the 3-bit index of the highest-priority pending line through a valid/ready handshake, one index per transfer. It is the encoding counterpart of the 3-to-8 decoder path: issued indices feed directly into a 3-to-8 decoder downstream.

## Interface
- PRIORITY_HIGH, default 1: 1 gives bit 7 the highest priority; 0 gives bit 0 the highest priority.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  gates request capture and issue of new codes.
- req  in  8  request pulses, one bit per source.
- code_ready  in  1  consumer accepts `code` this cycle.
- clear_ovf  in  1  synchronous clear of `overflow`.
- code  out  3  binary index of the issued request.
- code_valid  out  1  `code` is valid.
- pending  out  8  registered pending-request vector.
- overflow  out  1  sticky flag: a request was merged into an already-pending bit.

## Operation
- Reset values: `pending`=0, `code`=0, `code_valid`=0, `overflow`=0, state=IDLE.
- Capture: when `enable`=1, set each pending bit whose `req` bit is 1. When `enable`=0, ignore `req`.
- Selection: combinational priority pick over `pending`, with polarity set by PRIORITY_HIGH.
- Only the issue step clears a pending bit.
- States:
  - IDLE: `code_valid`=0.
    - If `enable`=1 and `pending`≠0: load `code` with the selected index, clear that pending bit, and go to PRESENT.
  - PRESENT: `code_valid`=1.
    - `code` is held stable until the handshake completes, even if `enable` drops.
    - A transfer occurs on an edge where `code_valid`=1 and `code_ready`=1.
    - On a transfer with `enable`=1 and `pending`≠0: load the next code at that same edge (back-to-back) and stay in PRESENT.
    - On a transfer otherwise: go to IDLE.
- Candidate set for a back-to-back issue: the `pending` register value before this edge's capture. Requests captured on the same edge are not eligible until the next edge.
- Set/clear collision: if a `req` bit is 1 while the same bit is cleared by issue, the bit ends set. The new request is kept.
- Overflow: set when `enable`=1, `req[i]`=1, `pending[i]`=1, and bit i is not being cleared this edge.
  - Cleared only by `clear_ovf`=1 or `rst`.
  - If set and clear happen on the same edge, set wins.
- `rst` asserted mid-transfer: all state returns to reset values immediately, with no wait for the clock. Pending requests are lost.

## Timing
- Latency from an idle block: `req` high in cycle N; `pending` updates at the end of N; `code_valid` rises at the end of N+1. Total: 2 edges.
- Throughput: one code per cycle while `code_ready`=1 and requests remain.
- `code` and `code_valid` are registered outputs with no combinational path from any input.
- `code_ready` is ignored while `code_valid`=0.
- `pending` as an output shows the register value, i.e. after capture and clear.

## Test plan
- Reset and basic issue: assert `rst` asynchronously mid-cycle and release. Then pulse `req`=8'b0010_0000 for 1 cycle with `code_ready`=1. Required: all outputs 0 after reset, `code`=5 with `code_valid`=1 exactly 2 edges after the pulse, `pending`=0 afterwards.
- Priority ordering: pulse `req`=8'b1000_0101 for 1 cycle, `code_ready`=1 continuously.
  - PRIORITY_HIGH=1: codes 7, 2, 0 on consecutive cycles, then `code_valid`=0.
  - PRIORITY_HIGH=0: codes 0, 2, 7.
- Backpressure: pulse `req`=8'h03 with `code_ready`=0 for 4 cycles, then 1. Required: `code`=1 held stable with `code_valid`=1 throughout the stall, then 1 followed by 0 on consecutive cycles.
- Overflow and collision:
  - Pulse `req`=8'h10 twice while the bit is pending and `code_ready`=0. Required: `overflow`=1 after the second pulse, and only one code 4 issued.
  - Re-pulse bit 4 on the exact edge it is issued. Required: `overflow` stays unchanged, a second code 4 is issued later, `clear_ovf` clears the flag.
- Enable gating: with `enable`=0, pulse `req`=8'hFF. Required: `pending` stays 0 and nothing is issued.
  - Preload `pending`=8'h06, then drop `enable` while PRESENT. Required: the current code completes its handshake and no further code is issued until `enable`=1.
- Reset mid-operation: with `pending`=8'hF0 and `code_valid`=1, assert `rst` for 1 cycle. Required: `pending`=0 and `code_valid`=0 immediately, and no codes issued after release.

Source files
------------

// File: rtl/priority_encoder_8x3.sv
// Sequential 8-to-3 priority encoder: request pulses accumulate in a pending register and
// the selected index is issued one per valid/ready transfer, with a sticky overflow flag.
module priority_encoder_8x3 #(
  parameter int unsigned PRIORITY_HIGH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] req_i,
  input  logic       code_ready_i,
  input  logic       clear_ovf_i,
  output logic [2:0] code_o,
  output logic       code_valid_o,
  output logic [7:0] pending_o,
  output logic       overflow_o
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic       code_valid_q, code_valid_d;
  logic       overflow_q, overflow_d;

  logic [2:0] sel_idx;
  logic [7:0] sel_mask;
  logic [7:0] clr_mask;
  logic [7:0] cap;
  logic       issue;

  // Later loop iterations win, so scan order sets the polarity.
  always_comb begin
    sel_idx = '0;
    if (PRIORITY_HIGH != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end
  end

  assign sel_mask = 8'b1 << sel_idx;

  always_comb begin
    cap   = enable_i ? req_i : '0;
    // Candidates come from pending_q only; same-edge captures wait for the next edge.
    issue = enable_i && (pending_q != '0) && ((state_q == StIdle) || code_ready_i);
    clr_mask = issue ? sel_mask : '0;
    // Capture is OR-ed after the clear so a colliding new request survives.
    pending_d  = (pending_q & ~clr_mask) | cap;
    overflow_d = (|(cap & pending_q & ~clr_mask)) | (overflow_q & ~clear_ovf_i);

    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          code_d  = sel_idx;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (code_ready_i) begin
          if (issue) code_d = sel_idx;
          else       state_d = StIdle;
        end
      end
    endcase
    code_valid_d = (state_d == StPresent);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign code_o       = code_q;
  assign code_valid_o = code_valid_q;
  assign pending_o    = pending_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Bench for priority_encoder_8x3: drives both priority polarities side by side and checks
// issued codes against an expected-code scoreboard plus cycle-exact output checks.
module tb_priority_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst, enable, code_ready, clear_ovf;
  logic [7:0] req;
  logic [2:0] code_h, code_l;
  logic       vh, vl, ovf_h, ovf_l;
  logic [7:0] pend_h, pend_l;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_h[$];
  logic [2:0] exp_l[$];
  logic [2:0] obs_h[$];
  logic [2:0] obs_l[$];

  always #5 clk = ~clk;

  priority_encoder_8x3 #(.PRIORITY_HIGH(1)) u_dut_h (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req), .code_ready_i(code_ready),
    .clear_ovf_i(clear_ovf), .code_o(code_h), .code_valid_o(vh), .pending_o(pend_h),
    .overflow_o(ovf_h)
  );

  priority_encoder_8x3 #(.PRIORITY_HIGH(0)) u_dut_l (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req), .code_ready_i(code_ready),
    .clear_ovf_i(clear_ovf), .code_o(code_l), .code_valid_o(vl), .pending_o(pend_l),
    .overflow_o(ovf_l)
  );

  // A transfer happens on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst && code_ready) begin
      if (vh) obs_h.push_back(code_h);
      if (vl) obs_l.push_back(code_l);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_vec++;
    if ({code_h, vh, pend_h, ovf_h, code_l, vl, pend_l, ovf_l} !== '0) begin
      n_err++;
      $display("FAIL reset_init: got %0h/%0h/%0h/%0h want all zero", code_h, vh, pend_h, ovf_h);
    end
    rst = 1'b0;
    cyc(1);
    enable = 1'b1;
    req = 8'h01;
    cyc(1);
    req = 8'h00;
    cyc(1);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({code_h, vh, pend_h, ovf_h, code_l, vl, pend_l, ovf_l} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got valid %0b/%0b pend %0h/%0h want zero", vh, vl, pend_h, pend_l);
    end
    cyc(1);
    rst = 1'b0;
    obs_h.delete();
    obs_l.delete();
  endtask

  task automatic test_basic();
    logic [2:0] e, o;
    code_ready = 1'b1;
    req = 8'h20;
    exp_h.push_back(3'd5);
    exp_l.push_back(3'd5);
    cyc(1);
    req = 8'h00;
    n_vec++;
    if (vh !== 1'b0 || pend_h !== 8'h20) begin
      n_err++;
      $display("FAIL basic_edge1: valid %0b pend %0h want 0 20", vh, pend_h);
    end
    cyc(1);
    n_vec++;
    if ({vh, code_h, vl, code_l, pend_h, pend_l} !== {1'b1, 3'd5, 1'b1, 3'd5, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL basic_edge2: code %0d/%0d valid %0b/%0b pend %0h want 5/5 1/1 0",
               code_h, code_l, vh, vl, pend_h);
    end
    cyc(3);
    n_vec++;
    if (obs_h.size() != exp_h.size() || obs_l.size() != exp_l.size()) begin
      n_err++;
      $display("FAIL basic_count: got %0d/%0d codes want %0d/%0d",
               obs_h.size(), obs_l.size(), exp_h.size(), exp_l.size());
    end
    while (exp_h.size() > 0 && obs_h.size() > 0) begin
      e = exp_h.pop_front(); o = obs_h.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL basic_seq_h: code %0d want %0d", o, e); end
    end
    while (exp_l.size() > 0 && obs_l.size() > 0) begin
      e = exp_l.pop_front(); o = obs_l.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL basic_seq_l: code %0d want %0d", o, e); end
    end
    exp_h.delete(); exp_l.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_priority();
    logic [2:0] e, o;
    logic [2:0] want_h[3];
    logic [2:0] want_l[3];
    want_h = '{3'd7, 3'd2, 3'd0};
    want_l = '{3'd0, 3'd2, 3'd7};
    code_ready = 1'b1;
    req = 8'b1000_0101;
    for (int i = 0; i < 3; i++) begin
      exp_h.push_back(want_h[i]);
      exp_l.push_back(want_l[i]);
    end
    cyc(1);
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_vec++;
      if ({vh, code_h, vl, code_l} !== {1'b1, want_h[i], 1'b1, want_l[i]}) begin
        n_err++;
        $display("FAIL prio_cycle%0d: code %0d/%0d valid %0b/%0b want %0d/%0d",
                 i, code_h, code_l, vh, vl, want_h[i], want_l[i]);
      end
    end
    cyc(1);
    n_vec++;
    if (vh !== 1'b0 || vl !== 1'b0) begin
      n_err++;
      $display("FAIL prio_drain: valid %0b/%0b want 0/0", vh, vl);
    end
    n_vec++;
    if (obs_h.size() != exp_h.size() || obs_l.size() != exp_l.size()) begin
      n_err++;
      $display("FAIL prio_count: got %0d/%0d codes want %0d/%0d",
               obs_h.size(), obs_l.size(), exp_h.size(), exp_l.size());
    end
    while (exp_h.size() > 0 && obs_h.size() > 0) begin
      e = exp_h.pop_front(); o = obs_h.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL prio_seq_h: code %0d want %0d", o, e); end
    end
    while (exp_l.size() > 0 && obs_l.size() > 0) begin
      e = exp_l.pop_front(); o = obs_l.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL prio_seq_l: code %0d want %0d", o, e); end
    end
    exp_h.delete(); exp_l.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_backpressure();
    logic [2:0] e, o;
    code_ready = 1'b0;
    req = 8'h03;
    exp_h.push_back(3'd1); exp_h.push_back(3'd0);
    exp_l.push_back(3'd0); exp_l.push_back(3'd1);
    cyc(1);
    req = 8'h00;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({vh, code_h, vl, code_l} !== {1'b1, 3'd1, 1'b1, 3'd0}) begin
        n_err++;
        $display("FAIL stall%0d: code %0d/%0d valid %0b/%0b want 1/0 1/1",
                 i, code_h, code_l, vh, vl);
      end
      cyc(1);
    end
    code_ready = 1'b1;
    cyc(1);
    n_vec++;
    if ({vh, code_h, vl, code_l} !== {1'b1, 3'd0, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL stall_release: code %0d/%0d want 0/1", code_h, code_l);
    end
    cyc(1);
    n_vec++;
    if (vh !== 1'b0 || vl !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain: valid %0b/%0b want 0/0", vh, vl);
    end
    n_vec++;
    if (obs_h.size() != exp_h.size() || obs_l.size() != exp_l.size()) begin
      n_err++;
      $display("FAIL bp_count: got %0d/%0d codes want %0d/%0d",
               obs_h.size(), obs_l.size(), exp_h.size(), exp_l.size());
    end
    while (exp_h.size() > 0 && obs_h.size() > 0) begin
      e = exp_h.pop_front(); o = obs_h.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL bp_seq_h: code %0d want %0d", o, e); end
    end
    while (exp_l.size() > 0 && obs_l.size() > 0) begin
      e = exp_l.pop_front(); o = obs_l.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL bp_seq_l: code %0d want %0d", o, e); end
    end
    exp_h.delete(); exp_l.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_overflow();
    logic [2:0] e, o;
    code_ready = 1'b0;
    req = 8'h01;
    exp_h.push_back(3'd0); exp_h.push_back(3'd4);
    exp_l.push_back(3'd0); exp_l.push_back(3'd4);
    cyc(1);
    req = 8'h00;
    cyc(1);
    req = 8'h10;
    cyc(1);
    req = 8'h00;
    cyc(1);
    n_vec++;
    if ({ovf_h, ovf_l, pend_h, pend_l} !== {1'b0, 1'b0, 8'h10, 8'h10}) begin
      n_err++;
      $display("FAIL ovf_first: ovf %0b/%0b pend %0h/%0h want 0/0 10/10", ovf_h, ovf_l, pend_h, pend_l);
    end
    req = 8'h10;
    cyc(1);
    req = 8'h00;
    n_vec++;
    if (ovf_h !== 1'b1 || ovf_l !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_second: ovf %0b/%0b want 1/1", ovf_h, ovf_l);
    end
    req = 8'h10;
    clear_ovf = 1'b1;
    cyc(1);
    req = 8'h00;
    n_vec++;
    if (ovf_h !== 1'b1 || ovf_l !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins: ovf %0b/%0b want 1/1", ovf_h, ovf_l);
    end
    cyc(1);
    clear_ovf = 1'b0;
    n_vec++;
    if (ovf_h !== 1'b0 || ovf_l !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: ovf %0b/%0b want 0/0", ovf_h, ovf_l);
    end
    code_ready = 1'b1;
    cyc(4);
    n_vec++;
    if (obs_h.size() != exp_h.size() || obs_l.size() != exp_l.size()) begin
      n_err++;
      $display("FAIL ovf_count: got %0d/%0d codes want %0d/%0d",
               obs_h.size(), obs_l.size(), exp_h.size(), exp_l.size());
    end
    while (exp_h.size() > 0 && obs_h.size() > 0) begin
      e = exp_h.pop_front(); o = obs_h.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL ovf_seq_h: code %0d want %0d", o, e); end
    end
    while (exp_l.size() > 0 && obs_l.size() > 0) begin
      e = exp_l.pop_front(); o = obs_l.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL ovf_seq_l: code %0d want %0d", o, e); end
    end
    exp_h.delete(); exp_l.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_collision();
    logic [2:0] e, o;
    code_ready = 1'b1;
    req = 8'h10;
    exp_h.push_back(3'd4); exp_h.push_back(3'd4);
    exp_l.push_back(3'd4); exp_l.push_back(3'd4);
    cyc(2);
    req = 8'h00;
    n_vec++;
    if ({vh, code_h, pend_h, ovf_h, vl, code_l, pend_l, ovf_l} !==
        {1'b1, 3'd4, 8'h10, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0}) begin
      n_err++;
      $display("FAIL collide_edge: code %0d pend %0h ovf %0b/%0b want 4 10 0/0",
               code_h, pend_h, ovf_h, ovf_l);
    end
    cyc(1);
    n_vec++;
    if ({vh, code_h, pend_h, vl, code_l, pend_l} !== {1'b1, 3'd4, 8'h00, 1'b1, 3'd4, 8'h00}) begin
      n_err++;
      $display("FAIL collide_reissue: code %0d valid %0b pend %0h want 4 1 0", code_h, vh, pend_h);
    end
    cyc(3);
    n_vec++;
    if (obs_h.size() != exp_h.size() || obs_l.size() != exp_l.size()) begin
      n_err++;
      $display("FAIL collide_count: got %0d/%0d codes want %0d/%0d",
               obs_h.size(), obs_l.size(), exp_h.size(), exp_l.size());
    end
    while (exp_h.size() > 0 && obs_h.size() > 0) begin
      e = exp_h.pop_front(); o = obs_h.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL collide_seq_h: code %0d want %0d", o, e); end
    end
    while (exp_l.size() > 0 && obs_l.size() > 0) begin
      e = exp_l.pop_front(); o = obs_l.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL collide_seq_l: code %0d want %0d", o, e); end
    end
    exp_h.delete(); exp_l.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_enable();
    logic [2:0] e, o;
    enable = 1'b0;
    code_ready = 1'b1;
    req = 8'hFF;
    cyc(1);
    req = 8'h00;
    cyc(2);
    n_vec++;
    if ({pend_h, pend_l, vh, vl} !== '0) begin
      n_err++;
      $display("FAIL en_gate: pend %0h/%0h valid %0b/%0b want 0", pend_h, pend_l, vh, vl);
    end
    code_ready = 1'b0;
    enable = 1'b1;
    req = 8'h06;
    exp_h.push_back(3'd2); exp_h.push_back(3'd1);
    exp_l.push_back(3'd1); exp_l.push_back(3'd2);
    cyc(1);
    req = 8'h00;
    cyc(1);
    enable = 1'b0;
    cyc(1);
    n_vec++;
    if ({vh, code_h, vl, code_l} !== {1'b1, 3'd2, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL en_hold: code %0d/%0d valid %0b/%0b want 2/1 1/1", code_h, code_l, vh, vl);
    end
    code_ready = 1'b1;
    cyc(3);
    n_vec++;
    if ({vh, pend_h, vl, pend_l} !== {1'b0, 8'h02, 1'b0, 8'h04}) begin
      n_err++;
      $display("FAIL en_paused: valid %0b/%0b pend %0h/%0h want 0/0 02/04", vh, vl, pend_h, pend_l);
    end
    enable = 1'b1;
    cyc(1);
    n_vec++;
    if ({vh, code_h, vl, code_l} !== {1'b1, 3'd1, 1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL en_resume: code %0d/%0d valid %0b/%0b want 1/2 1/1", code_h, code_l, vh, vl);
    end
    cyc(3);
    n_vec++;
    if (obs_h.size() != exp_h.size() || obs_l.size() != exp_l.size()) begin
      n_err++;
      $display("FAIL en_count: got %0d/%0d codes want %0d/%0d",
               obs_h.size(), obs_l.size(), exp_h.size(), exp_l.size());
    end
    while (exp_h.size() > 0 && obs_h.size() > 0) begin
      e = exp_h.pop_front(); o = obs_h.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL en_seq_h: code %0d want %0d", o, e); end
    end
    while (exp_l.size() > 0 && obs_l.size() > 0) begin
      e = exp_l.pop_front(); o = obs_l.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL en_seq_l: code %0d want %0d", o, e); end
    end
    exp_h.delete(); exp_l.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_reset_mid();
    code_ready = 1'b0;
    enable = 1'b1;
    req = 8'h01;
    cyc(1);
    req = 8'hF0;
    cyc(1);
    req = 8'h00;
    n_vec++;
    if ({vh, pend_h, vl, pend_l} !== {1'b1, 8'hF0, 1'b1, 8'hF0}) begin
      n_err++;
      $display("FAIL rstmid_setup: valid %0b/%0b pend %0h/%0h want 1/1 F0/F0", vh, vl, pend_h, pend_l);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({vh, pend_h, vl, pend_l} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async: valid %0b/%0b pend %0h/%0h want 0", vh, vl, pend_h, pend_l);
    end
    cyc(1);
    rst = 1'b0;
    code_ready = 1'b1;
    cyc(4);
    n_vec++;
    if (obs_h.size() != 0 || obs_l.size() != 0 || vh !== 1'b0 || vl !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_quiet: %0d/%0d codes issued, valid %0b/%0b, want none",
               obs_h.size(), obs_l.size(), vh, vl);
    end
    obs_h.delete(); obs_l.delete();
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    req = 8'h00;
    code_ready = 1'b0;
    clear_ovf = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_backpressure();
    test_overflow();
    test_collision();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
